// File: rtl/usb_txn_arbiter.sv
// Round-robin arbiter sharing one USB transaction engine between two requesters,
// with NAK backoff/retry, bounded error retry and one final result per request.
module usb_txn_arbiter #(
  parameter int NAK_LIMIT   = 8,
  parameter int ERR_RETRIES = 3,
  parameter int NAK_BACKOFF = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_type,
  input  logic [13:0] req_addr,
  input  logic [7:0]  req_endp,
  input  logic [1:0]  req_data_pid,
  input  logic [15:0] req_len,
  output logic [1:0]  req_ready,
  output logic [1:0]  req_done,
  output logic [5:0]  req_result,
  output logic        eng_start,
  output logic [1:0]  eng_type,
  output logic [6:0]  eng_addr,
  output logic [3:0]  eng_endp,
  output logic        eng_data_pid,
  output logic [7:0]  eng_len,
  input  logic        eng_ready,
  input  logic        eng_done,
  input  logic [2:0]  eng_result,
  output logic        grant_id,
  output logic        busy
);

  localparam int NW = (NAK_LIMIT > 0) ? $clog2(NAK_LIMIT + 1) : 1;
  localparam int EW = (ERR_RETRIES > 0) ? $clog2(ERR_RETRIES + 1) : 1;
  localparam int BW = $clog2(NAK_BACKOFF + 1);
  localparam logic [NW-1:0] NAK_LIM = NW'(NAK_LIMIT);
  localparam logic [EW-1:0] ERR_LIM = EW'(ERR_RETRIES);
  localparam logic [BW-1:0] BO_LOAD = BW'(NAK_BACKOFF);
  localparam logic [BW-1:0] BO_LAST = BW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last_grant, r_grant_id;
  logic [NW-1:0]   r_nak_cnt;
  logic [EW-1:0]   r_err_cnt;
  logic [BW-1:0]   r_backoff;
  logic [1:0]      r_req_ready, r_req_done;
  logic [5:0]      r_req_result;
  logic            r_eng_start;
  logic [1:0]      r_type;
  logic [6:0]      r_addr;
  logic [3:0]      r_endp;
  logic            r_pid;
  logic [7:0]      r_len;

  logic            w_grant, w_issue, w_final, w_nak_retry, w_err_retry;
  logic            w_gnt_id;

  // Tie goes to whoever did not win last; otherwise the lone valid requester.
  assign w_gnt_id = (&req_valid) ? ~r_last_grant : req_valid[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    // NOTE: state and all registered datapath use non-blocking assignments so every
    // flop samples pre-edge values, independent of process evaluation order.
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    w_final     = 1'b0;
    w_nak_retry = 1'b0;
    w_err_retry = 1'b0;
    case (r_state)
      S_IDLE: if (eng_ready && |req_valid) begin
        w_grant     = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (eng_ready) begin
        w_issue     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (eng_done) begin
        case (eng_result)
          3'd2: if (r_nak_cnt < NAK_LIM) begin
            w_nak_retry = 1'b1;
            w_state_nxt = S_BACKOFF;
          end else begin
            w_final     = 1'b1;
            w_state_nxt = S_IDLE;
          end
          3'd4, 3'd5: if (r_err_cnt < ERR_LIM) begin
            w_err_retry = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_final     = 1'b1;
            w_state_nxt = S_IDLE;
          end
          default: begin
            w_final     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        endcase
      end
      S_BACKOFF: if (r_backoff == BO_LAST) w_state_nxt = S_ISSUE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_nak_cnt    <= '0;
      r_err_cnt    <= '0;
      r_backoff    <= '0;
      r_req_ready  <= '0;
      r_req_done   <= '0;
      r_req_result <= '0;
      r_eng_start  <= 1'b0;
      r_type       <= '0;
      r_addr       <= '0;
      r_endp       <= '0;
      r_pid        <= 1'b0;
      r_len        <= '0;
    end else begin
      r_req_ready <= '0;
      r_req_done  <= '0;
      r_eng_start <= w_issue;
      if (w_grant) begin
        r_grant_id            <= w_gnt_id;
        r_req_ready[w_gnt_id] <= 1'b1;
        r_type    <= w_gnt_id ? req_type[3:2]   : req_type[1:0];
        r_addr    <= w_gnt_id ? req_addr[13:7]  : req_addr[6:0];
        r_endp    <= w_gnt_id ? req_endp[7:4]   : req_endp[3:0];
        r_pid     <= req_data_pid[w_gnt_id];
        r_len     <= w_gnt_id ? req_len[15:8]   : req_len[7:0];
        r_nak_cnt <= '0;
        r_err_cnt <= '0;
      end
      if (w_nak_retry) begin
        r_nak_cnt <= r_nak_cnt + 1'b1;
        r_backoff <= BO_LOAD;
      end
      if (r_state == S_BACKOFF) r_backoff <= r_backoff - 1'b1;
      if (w_err_retry) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_final) begin
        if (r_grant_id) r_req_result[5:3] <= eng_result;
        else            r_req_result[2:0] <= eng_result;
        r_req_done[r_grant_id] <= 1'b1;
        r_last_grant           <= r_grant_id;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign req_done     = r_req_done;
  assign req_result   = r_req_result;
  assign eng_start    = r_eng_start;
  assign eng_type     = r_type;
  assign eng_addr     = r_addr;
  assign eng_endp     = r_endp;
  assign eng_data_pid = r_pid;
  assign eng_len      = r_len;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/usb_txn_arbiter.md
# usb_txn_arbiter

Shares one USB transaction engine between two requesters (req 0: enumeration/control FSM, req 1: interrupt-endpoint poller). Round-robin arbitration, latching of the granted request, automatic retry of NAKed transactions after a fixed backoff, bounded retry of TIMEOUT/CRC_ERROR, and a single final result per request. Sits between the host-side requesters and the transaction engine's trans_* port. `grant_id` also steers the engine's data_in/data_out mux.

## Interface
- NAK_LIMIT, 8: max NAK retries per request (0 = report first NAK).
- ERR_RETRIES, 3: max re-issues after TIMEOUT(4)/CRC_ERROR(5).
- NAK_BACKOFF, 64: idle cycles between a NAK and re-issue (>=1).

- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit g = requester g has a transaction pending.
- req_type  in  4  [2g+1:2g]; 00 SETUP, 01 IN, 10 OUT.
- req_addr  in  14  [7g+6:7g] device address.
- req_endp  in  8  [4g+3:4g] endpoint.
- req_data_pid  in  2  DATA0=0/DATA1=1.
- req_len  in  16  [8g+7:8g] data length.
- req_ready  out  2  1-cycle accept pulse; fields latched that cycle.
- req_done  out  2  1-cycle completion pulse.
- req_result  out  6  [3g+2:3g] final result; held until that requester's next done.
- eng_start  out  1  1-cycle pulse to engine trans_start.
- eng_type, eng_addr, eng_endp, eng_data_pid, eng_len  out  2/7/4/1/8  latched request fields to the engine.
- eng_ready  in  1  engine trans_ready.
- eng_done  in  1  engine trans_done.
- eng_result  in  3  0 NONE, 1 ACK, 2 NAK, 3 STALL, 4 TIMEOUT, 5 CRC_ERROR.
- grant_id  out  1  owner of the engine; stable from grant to done.
- busy  out  1  high outside IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, BACKOFF.
- IDLE: if eng_ready and any req_valid, grant:
  - If both requesters are valid, grant `!last_grant`.
  - Otherwise grant the single valid requester.
  - On grant: latch fields, pulse req_ready[g], set grant_id=g, clear nak_cnt and err_cnt, go to ISSUE.
- ISSUE: when eng_ready, pulse eng_start and go to WAIT. Latched fields drive the eng_* outputs; data PID is unchanged across retries.
- WAIT, on eng_done:
  - ACK, STALL, or codes 0/6/7: final.
  - NAK: if nak_cnt < NAK_LIMIT, increment nak_cnt, load backoff=NAK_BACKOFF, go to BACKOFF. Otherwise final.
  - 4/5: if err_cnt < ERR_RETRIES, increment err_cnt and go to ISSUE. Otherwise final with that code.
  - eng_done outside WAIT is ignored.
- BACKOFF: decrement each cycle; when it reaches 0, go to ISSUE.
- Final: req_result[g] <= eng_result, pulse req_done[g], last_grant <= g, go to IDLE.
- nak_cnt and err_cnt are independent. Counter widths: clog2(limit+1); saturating is not needed because the comparisons bound them.
- req_valid is not sampled after grant. A requester still asserting req_valid after its req_done is treated as a new request.

## Timing
- Reset values: all outputs 0, grant_id 0, state IDLE, last_grant 1 (req 0 wins first tie), counters 0. Reset mid-transaction drops the request silently with no req_done.
- Grant: req_valid and eng_ready sampled at cycle N → req_ready at N+1; eng_start at N+2 if eng_ready is high at N+1.
- eng_done at M (final) → req_done and req_result at M+1. A new grant is possible at M+2 at the earliest.
- Error retry: eng_done at M → eng_start at M+2 (with eng_ready high).
- NAK retry: eng_done at M → BACKOFF for NAK_BACKOFF cycles → eng_start at M+NAK_BACKOFF+2.
- eng_start is never asserted while eng_ready is low; it is at most one pulse per issue.

## Test plan
- Single request: req 0 IN, addr 5, ep 1, engine returns ACK → exactly one eng_start with type 01, addr 5, ep 1; req_done[0] with result 1; grant_id stays 0 throughout.
- Contention: both valid from reset, each returns ACK → grant order 0,1,0,1 across four back-to-back requests; req_ready never both high.
- NAK retry: engine NAKs 3 times then ACKs → 4 eng_starts, each spaced NAK_BACKOFF+2 cycles after the preceding eng_done; result 1. With 9 NAKs (NAK_LIMIT=8) → 9 starts, then result 2.
- Error retry: engine returns TIMEOUT 4 times → 4 starts (1 + ERR_RETRIES), then result 4. CRC_ERROR followed by ACK → result 1.
- Reset in WAIT/BACKOFF: assert rst → all outputs 0 immediately and no req_done. After release with both requesters valid, req 0 is granted first.
- Spurious eng_done in IDLE, and eng_ready low in ISSUE for 10 cycles → no state change and no eng_start until eng_ready rises.
